// File: rtl/rx_bit_timer.sv
// Bit-timing stage of the serial receiver. Counts clocks per bit and bits per
// packet, and emits a mid-bit sample strobe plus a one-cycle end-of-packet pulse.
module rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT  = 10,
  parameter int unsigned SAMPLE_OFFSET = 4,
  parameter int unsigned DATA_BITS     = 8,
  localparam int unsigned IW = $clog2(DATA_BITS + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          enable_timer,
  output logic          shift_strobe,
  output logic [IW-1:0] bit_index,
  output logic          stop_strobe,
  output logic          packet_done,
  output logic          busy
);

  localparam int unsigned    CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(SAMPLE_OFFSET);
  localparam logic [IW-1:0] STOP_IDX  = IW'(DATA_BITS);

  logic [CW-1:0] clk_cnt;
  logic [IW-1:0] bit_cnt;
  logic          done;
  logic          pkt_done_q;
  logic          run;

  // Gating with n_rst keeps every output low while reset is held, even with
  // enable_timer high.
  assign run          = n_rst & enable_timer & ~done;
  assign shift_strobe = run & (clk_cnt == SAMPLE_AT);
  assign stop_strobe  = shift_strobe & (bit_cnt == STOP_IDX);
  assign bit_index    = bit_cnt;
  assign busy         = run;
  assign packet_done  = pkt_done_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      done       <= 1'b0;
      pkt_done_q <= 1'b0;
    end else if (!enable_timer) begin
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      done       <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      pkt_done_q <= stop_strobe;
      // Freezing on the stop edge keeps bit_cnt in range even when the sample
      // point is the last clock of the bit period.
      if (stop_strobe) begin
        done <= 1'b1;
      end else if (!done) begin
        if (clk_cnt == CLK_LAST) begin
          clk_cnt <= '0;
          bit_cnt <= bit_cnt + 1'b1;
        end else begin
          clk_cnt <= clk_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Self-checking bench for rx_bit_timer: directed scenarios plus random enable/reset
// traffic, checked against a cycle-count reference model.
module tb_rx_bit_timer;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       en_a = 1'b0, en_b = 1'b0;
  logic       sa, sta, pda, busya;
  logic [3:0] bia;
  logic       sb, stb, pdb, busyb;
  logic [2:0] bib;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rx_bit_timer dut_a (
    .clk(clk), .n_rst(n_rst), .enable_timer(en_a),
    .shift_strobe(sa), .bit_index(bia), .stop_strobe(sta),
    .packet_done(pda), .busy(busya)
  );

  rx_bit_timer #(.CLKS_PER_BIT(16), .SAMPLE_OFFSET(7), .DATA_BITS(7)) dut_b (
    .clk(clk), .n_rst(n_rst), .enable_timer(en_b),
    .shift_strobe(sb), .bit_index(bib), .stop_strobe(stb),
    .packet_done(pdb), .busy(busyb)
  );

  // Reference model: t = enabled, not-yet-done cycles since the last clear.
  // Strobe k sits at t = k*CPB + OFF; the packet ends after the strobe with k = DB.
  int cpb[2] = '{10, 16};
  int off[2] = '{4, 7};
  int db[2]  = '{8, 7};
  int t[2];
  bit fin[2];
  bit pd[2];

  function automatic bit en_of(int i);
    return n_rst && ((i == 0) ? en_a : en_b);
  endfunction

  function automatic bit m_strobe(int i);
    return en_of(i) && !fin[i] && ((t[i] % cpb[i]) == off[i]);
  endfunction

  function automatic bit m_stop(int i);
    return m_strobe(i) && ((t[i] / cpb[i]) == db[i]);
  endfunction

  always @(posedge clk or negedge n_rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!en_of(i)) begin
        t[i] <= 0; fin[i] <= 1'b0; pd[i] <= 1'b0;
      end else begin
        pd[i] <= m_stop(i);
        if (m_stop(i)) fin[i] <= 1'b1;
        else if (!fin[i]) t[i] <= t[i] + 1;
      end
    end
  end

  // {strobe, stop, packet_done, busy, bit_index (only meaningful on a strobe)}
  function automatic logic [7:0] exp_v(int i);
    logic s;
    s = m_strobe(i);
    return {s, m_stop(i), pd[i], en_of(i) && !fin[i], s ? 4'(t[i] / cpb[i]) : 4'd0};
  endfunction

  function automatic logic [7:0] got_v(int i);
    if (i == 0) return {sa, sta, pda, busya, sa ? bia : 4'd0};
    return {sb, stb, pdb, busyb, sb ? {1'b0, bib} : 4'd0};
  endfunction

  task automatic idle();
    en_a = 1'b0; en_b = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int first;
    logic [3:0] fi;
    n_rst = 1'b0; en_a = 1'b1; en_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if ({got_v(0), got_v(1)} !== 16'h0) begin
        n_err++; $display("FAIL reset_hold c=%0d got=%h/%h exp=0", c, got_v(0), got_v(1));
      end
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    first = -1; fi = 4'hf;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_chk++;
      if (got_v(0) !== exp_v(0)) begin
        n_err++; $display("FAIL reset_release c=%0d got=%h exp=%h", c, got_v(0), exp_v(0));
      end
      if (sa && first < 0) begin first = c; fi = bia; end
      @(posedge clk); #1;
    end
    n_chk++;
    if (first != 4 || fi !== 4'd0) begin
      n_err++; $display("FAIL reset_first_strobe cycle=%0d idx=%0d exp cycle=4 idx=0", first, fi);
    end
    idle();
  endtask

  task automatic test_full_packet();
    int ns, nstop, npd, first, last, pdc;
    logic busy86;
    ns = 0; nstop = 0; npd = 0; first = -1; last = -1; pdc = -1; busy86 = 1'b1;
    en_a = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_chk++;
      if (got_v(0) !== exp_v(0)) begin
        n_err++; $display("FAIL full_pkt c=%0d got=%h exp=%h", c, got_v(0), exp_v(0));
      end
      if (sa) begin
        n_chk++;
        if (bia !== 4'(ns)) begin
          n_err++; $display("FAIL full_pkt_idx c=%0d got=%0d exp=%0d", c, bia, ns);
        end
        if (first < 0) first = c;
        last = c; ns++;
      end
      if (sta) nstop++;
      if (pda) begin npd++; pdc = c; end
      if (c == 86) busy86 = busya;
      @(posedge clk); #1;
    end
    n_chk++;
    if (ns != 9 || first != 4 || last != 84 || nstop != 1 || npd != 1 || pdc != 85 || busy86 !== 1'b0) begin
      n_err++;
      $display("FAIL full_pkt_summary strobes=%0d first=%0d last=%0d stops=%0d pd=%0d@%0d busy86=%b exp 9/4/84/1/1@85/0",
               ns, first, last, nstop, npd, pdc, busy86);
    end
    idle();
  endtask

  task automatic test_linger();
    int ns, npd, first;
    ns = 0; npd = 0; first = -1;
    en_a = 1'b1;
    for (int c = 0; c < 116; c++) begin
      @(negedge clk);
      n_chk++;
      if (got_v(0) !== exp_v(0)) begin
        n_err++; $display("FAIL linger c=%0d got=%h exp=%h", c, got_v(0), exp_v(0));
      end
      if (sa) ns++;
      if (pda) npd++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (ns != 9 || npd != 1) begin
      n_err++; $display("FAIL linger_counts strobes=%0d pd=%0d exp 9/1", ns, npd);
    end
    en_a = 1'b0;
    @(posedge clk); #1;
    en_a = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (sa && first < 0) begin
        first = c;
        n_chk++;
        if (bia !== 4'd0) begin
          n_err++; $display("FAIL linger_restart_idx got=%0d exp=0", bia);
        end
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (first != 4) begin
      n_err++; $display("FAIL linger_restart cycle=%0d exp=4", first);
    end
    idle();
  endtask

  task automatic test_abort();
    int sc[$];
    int npd;
    logic [3:0] idx54;
    npd = 0; idx54 = 4'hf;
    for (int c = 0; c < 70; c++) begin
      en_a = !(c >= 37 && c < 50);
      @(negedge clk);
      n_chk++;
      if (got_v(0) !== exp_v(0)) begin
        n_err++; $display("FAIL abort c=%0d got=%h exp=%h", c, got_v(0), exp_v(0));
      end
      if (sa) begin sc.push_back(c); if (c == 54) idx54 = bia; end
      if (pda) npd++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (sc.size() != 6 || sc[3] != 34 || sc[4] != 54 || sc[5] != 64 || idx54 !== 4'd0 || npd != 0) begin
      n_err++;
      $display("FAIL abort_summary strobes=%0d idx54=%0d pd=%0d exp 6 strobes (..34,54,64) idx54=0 pd=0",
               sc.size(), idx54, npd);
    end
    idle();
  endtask

  task automatic test_async_reset();
    int npd, pdc, first_after;
    npd = 0; pdc = -1; first_after = -1;
    en_a = 1'b1;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      n_chk++;
      if (got_v(0) !== exp_v(0)) begin
        n_err++; $display("FAIL async_rst c=%0d got=%h exp=%h", c, got_v(0), exp_v(0));
      end
      if (pda) begin npd++; pdc = c; end
      if (sa && c >= 60 && first_after < 0) first_after = c;
      if (c == 60) begin
        #1 n_rst = 1'b0;
        #1;
        n_chk++;
        if (got_v(0) !== 8'h0) begin
          n_err++; $display("FAIL async_rst_zero got=%h exp=0", got_v(0));
        end
        #1 n_rst = 1'b1;
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (npd != 1 || pdc != 145 || first_after != 64) begin
      n_err++;
      $display("FAIL async_rst_summary pd=%0d@%0d first_after=%0d exp 1@145 first=64", npd, pdc, first_after);
    end
    idle();
  endtask

  task automatic test_sweep();
    int ns, first, last, pdc, npd;
    ns = 0; first = -1; last = -1; pdc = -1; npd = 0;
    en_b = 1'b1;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      n_chk++;
      if (got_v(1) !== exp_v(1)) begin
        n_err++; $display("FAIL sweep c=%0d got=%h exp=%h", c, got_v(1), exp_v(1));
      end
      if (sb) begin
        n_chk++;
        if (bib !== 3'(ns)) begin
          n_err++; $display("FAIL sweep_idx c=%0d got=%0d exp=%0d", c, bib, ns);
        end
        if (first < 0) first = c;
        last = c; ns++;
      end
      if (pdb) begin npd++; pdc = c; end
      @(posedge clk); #1;
    end
    n_chk++;
    if (ns != 8 || first != 7 || last != 119 || npd != 1 || pdc != 120) begin
      n_err++;
      $display("FAIL sweep_summary strobes=%0d first=%0d last=%0d pd=%0d@%0d exp 8/7/119/1@120",
               ns, first, last, npd, pdc);
    end
    idle();
  endtask

  task automatic test_random();
    int rem_a, rem_b, npd;
    rem_a = 1; rem_b = 1; npd = 0;
    for (int c = 0; c < 4000; c++) begin
      if (--rem_a == 0) begin en_a = ~en_a; rem_a = en_a ? $urandom_range(1, 140) : $urandom_range(1, 6); end
      if (--rem_b == 0) begin en_b = ~en_b; rem_b = en_b ? $urandom_range(1, 160) : $urandom_range(1, 6); end
      if ($urandom_range(0, 399) == 0) begin
        n_rst = 1'b0; #1 n_rst = 1'b1;
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (got_v(i) !== exp_v(i)) begin
          n_err++; $display("FAIL random inst=%0d c=%0d got=%h exp=%h", i, c, got_v(i), exp_v(i));
        end
      end
      if (pda || pdb) npd++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (npd == 0) begin
      n_err++; $display("FAIL random_coverage packet_done_seen=0 exp>0");
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_linger();
    test_abort();
    test_async_reset();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
